seg_scan_driver: RTL

- Receiving end of the 16-bit print word produced by the game's print-select logic.
- Holds a frame-coherent shadow copy of the word and time-multiplexes it onto a 4-digit common-anode seven-segment display, one digit per scan slot.
- Optional blink is used for the match-result and game-result screens.
- Sits between the print-select logic and the board display pins.

---
 rtl/display_pkg.sv | 32 +++
 rtl/seg_decode.sv | 35 +++
 rtl/seg_scan_driver.sv | 124 ++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared seven-segment display constants: active-low segment patterns, blank code, digit count.
// Pure definitions, no logic and no latency.
// No flow control; consumed by the scan driver and any other display block.
package display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}, a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/seg_decode.sv
// 4-bit display code to active-low seven-segment pattern; code F is blank.
// Purely combinational, zero latency.
// No flow control.
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  // Map each code to its glyph; anything unlisted falls back to blank.
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:       seg = SEG_0;
      4'h1:       seg = SEG_1;
      4'h2:       seg = SEG_2;
      4'h3:       seg = SEG_3;
      4'h4:       seg = SEG_4;
      4'h5:       seg = SEG_5;
      4'h6:       seg = SEG_6;
      4'h7:       seg = SEG_7;
      4'h8:       seg = SEG_8;
      4'h9:       seg = SEG_9;
      4'hA:       seg = SEG_A;
      4'hB:       seg = SEG_B;
      4'hC:       seg = SEG_C;
      4'hD:       seg = SEG_D;
      4'hE:       seg = SEG_E;
      CODE_BLANK: seg = SEG_BLANK;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Frame-coherent 4-digit common-anode seven-segment scanner with optional whole-display blink.
// an/seg are registered: one cycle behind the digit index and shadow word; frame_done is combinational.
// No backpressure; print_word is sampled only at frame boundaries (and right after reset).
module seg_scan_driver
  import display_pkg::*;
#(
  parameter int DIV          = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] print_word,
  input  logic        blink_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int SW = $clog2(DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [SW-1:0]  slot_q, slot_d;
  logic [DW-1:0]  dig_q, dig_d;
  logic [15:0]    shadow_q, shadow_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  blink_phase_e   phase_q, phase_d;
  logic           first_q, first_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  logic           slot_last;
  logic           frame_end;
  logic           blank;
  logic [3:0]     nib;
  logic [3:0]     code;
  logic [6:0]     dec_seg;

  // Digit nibbles are stored bit-reversed, so flip before decoding.
  assign nib  = 4'(shadow_q >> {dig_q, 2'b00});
  assign code = {nib[0], nib[1], nib[2], nib[3]};

  seg_decode u_decode (
    .code (code),
    .seg  (dec_seg)
  );

  // Next-state: scan counters, frame-boundary shadow capture, blink phase and output patterns.
  always_comb begin
    slot_d      = slot_q;
    dig_d       = dig_q;
    shadow_d    = shadow_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    first_d     = 1'b0;
    an_d        = 4'b1111;
    seg_d       = SEG_BLANK;

    slot_last = (slot_q == SLOT_LAST);
    frame_end = slot_last && (dig_q == DIG_LAST);

    slot_d = slot_last ? '0 : slot_q + SW'(1);
    if (slot_last) begin
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DW'(1);
    end

    // Capture only between frames so a frame never mixes two words.
    if (first_q || frame_end) begin
      shadow_d = print_word;
    end

    // Blink state is parked at count 0 / ON whenever blink is disabled.
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = PH_ON;
    end else if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    blank = blink_en && (phase_q == PH_OFF);
    if (!blank) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = dec_seg;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= '0;
      dig_q       <= '0;
      shadow_q    <= 16'hFFFF;
      blink_cnt_q <= '0;
      phase_q     <= PH_ON;
      first_q     <= 1'b1;
      an_q        <= 4'b1111;
      seg_q       <= SEG_BLANK;
    end else begin
      slot_q      <= slot_d;
      dig_q       <= dig_d;
      shadow_q    <= shadow_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      first_q     <= first_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_end;

endmodule
